// File: rtl/machine_csr_file_pkg.sv
// Shared types and constants for the machine-mode CSR file: operations, cause codes,
// CSR addresses, mstatus layout and interrupt priority.
package machine_csr_file_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned IRQ_COUNT = 3;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csrOperation_e;

  typedef enum logic [1:0] {
    TRAP_MODE_DIRECT   = 2'd0,
    TRAP_MODE_VECTORED = 2'd1
  } trapMode_e;

  typedef enum logic [4:0] {
    EXC_INSTR_MISALIGNED = 5'd0,
    EXC_INSTR_ACCESS     = 5'd1,
    EXC_ILLEGAL_INSTR    = 5'd2,
    EXC_BREAKPOINT       = 5'd3,
    EXC_LOAD_MISALIGNED  = 5'd4,
    EXC_LOAD_ACCESS      = 5'd5,
    EXC_STORE_MISALIGNED = 5'd6,
    EXC_STORE_ACCESS     = 5'd7,
    EXC_ECALL_M          = 5'd11
  } exceptionCode_e;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MTVAL      = 12'h343;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
  localparam logic [11:0] CSR_CYCLE      = 12'hC00;
  localparam logic [11:0] CSR_TIME       = 12'hC01;
  localparam logic [11:0] CSR_INSTRET    = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH     = 12'hC80;
  localparam logic [11:0] CSR_TIMEH      = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH   = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID    = 12'hF12;
  localparam logic [11:0] CSR_MIMPID     = 12'hF13;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;
  localparam logic [11:0] CSR_MCONFIGPTR = 12'hF15;

  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;
  localparam logic [1:0]  MSTATUS_MPP = 2'b11;
  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;
  localparam logic [31:0] IRQ_MASK    = 32'h0000_0888;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  // Highest priority first.
  localparam logic [4:0] IRQ_PRIORITY [IRQ_COUNT] = '{IRQ_MEI, IRQ_MSI, IRQ_MTI};

  // Returns {any, code} of the highest-priority pending interrupt.
  function automatic logic [5:0] irq_select(input logic [31:0] pend);
    logic [5:0] sel;
    sel = '0;
    for (int i = int'(IRQ_COUNT) - 1; i >= 0; i--) begin
      if (pend[IRQ_PRIORITY[i]]) sel = {1'b1, IRQ_PRIORITY[i]};
    end
    return sel;
  endfunction

endpackage

// File: rtl/machine_csr_file_counter64.sv
// 64-bit counter with per-half software write; any write suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0]  = wdata_i;
      if (wr_hi_i) count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign value_o = count_q;

endmodule

// File: rtl/machine_csr_file.sv
// Machine-mode CSR file: Zicsr read/modify/write, trap entry, MRET and the fetch redirect.
module machine_csr_file
  import machine_csr_file_pkg::*;
#(
  parameter logic [31:0] MHARTID_VAL = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           read_enable_i,
  input  logic           write_enable_i,
  input  csrOperation_e  operation_i,
  input  logic [11:0]    address_i,
  input  logic [31:0]    data_i,
  output logic [31:0]    out_o,
  output logic           illegal_o,
  input  logic           valid_i,
  input  logic [31:0]    pc_i,
  input  logic           exception_i,
  input  exceptionCode_e exception_code_i,
  input  logic [31:0]    tval_i,
  input  logic           mret_i,
  input  logic           instret_i,
  input  logic           meip_i,
  input  logic           msip_i,
  input  logic           mtip_i,
  output logic           irq_pending_o,
  output logic           jump_o,
  output logic [31:0]    jump_target_o
);

  logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d, mip_q, mip_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic        jump_q, jump_d;
  logic [31:0] jump_target_q, jump_target_d;

  logic [63:0] mcycle, minstret;
  logic [31:0] rdata, csr_new, pend;
  logic        legal, read_only, take_exc, take_irq, take_mret, csr_wr;
  logic [5:0]  irq_sel;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^pc_i[1:0];

  // Read mux and address decode.
  always_comb begin
    rdata = '0;
    legal = 1'b1;
    unique case (address_i)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MCONFIGPTR: rdata = '0;
      CSR_MHARTID:  rdata = MHARTID_VAL;
      CSR_MISA:     rdata = MISA_VALUE;
      CSR_MSTATUS: begin
        rdata[12:11]    = MSTATUS_MPP;
        rdata[MPIE_BIT] = mstatus_mpie_q;
        rdata[MIE_BIT]  = mstatus_mie_q;
      end
      CSR_MIE:      rdata = mie_q;
      CSR_MIP:      rdata = mip_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MCYCLE, CSR_CYCLE, CSR_TIME:        rdata = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH:     rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:              rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH:            rdata = minstret[63:32];
      default: legal = 1'b0;
    endcase
  end

  assign read_only = (address_i[11:10] == 2'b11) || (address_i == CSR_MISA);
  assign illegal_o = !legal || (write_enable_i && read_only);
  assign out_o     = (read_enable_i && !illegal_o) ? rdata : '0;

  always_comb begin
    unique case (operation_i)
      CSR_OP_SET:   csr_new = rdata | data_i;
      CSR_OP_CLEAR: csr_new = rdata & ~data_i;
      default:      csr_new = data_i;
    endcase
  end

  assign pend          = mip_q & mie_q;
  assign irq_sel       = irq_select(pend);
  assign irq_pending_o = mstatus_mie_q && (|pend);

  // Only the highest-priority event of the cycle takes effect.
  assign take_exc  = exception_i;
  assign take_irq  = !take_exc && irq_pending_o && valid_i;
  assign take_mret = !take_exc && !take_irq && mret_i;
  assign csr_wr    = write_enable_i && !illegal_o && (operation_i != CSR_OP_NONE)
                     && !take_exc && !take_irq && !take_mret;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    jump_d         = 1'b0;
    jump_target_d  = jump_target_q;
    mip_d          = '0;
    mip_d[IRQ_MEI] = meip_i;
    mip_d[IRQ_MSI] = msip_i;
    mip_d[IRQ_MTI] = mtip_i;

    if (take_exc || take_irq) begin
      mepc_d         = {pc_i[31:2], 2'b00};
      mcause_d       = take_exc ? {27'd0, 5'(exception_code_i)} : {1'b1, 26'd0, irq_sel[4:0]};
      mtval_d        = take_exc ? tval_i : '0;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      jump_d         = 1'b1;
      jump_target_d  = (take_irq && mtvec_q[0])
                       ? {mtvec_q[31:2], 2'b00} + {25'd0, irq_sel[4:0], 2'b00}
                       : {mtvec_q[31:2], 2'b00};
    end else if (take_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      jump_d         = 1'b1;
      jump_target_d  = mepc_q;
    end else if (csr_wr) begin
      unique case (address_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_new[MIE_BIT];
          mstatus_mpie_d = csr_new[MPIE_BIT];
        end
        CSR_MIE:      mie_d      = csr_new & IRQ_MASK;
        CSR_MTVEC:    mtvec_d    = {csr_new[31:2], 1'b0, csr_new[0]};
        CSR_MSCRATCH: mscratch_d = csr_new;
        CSR_MEPC:     mepc_d     = {csr_new[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = {csr_new[31], 26'd0, csr_new[4:0]};
        CSR_MTVAL:    mtval_d    = csr_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      jump_q         <= 1'b0;
      jump_target_q  <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      jump_q         <= jump_d;
      jump_target_q  <= jump_target_d;
    end
  end

  assign jump_o        = jump_q;
  assign jump_target_o = jump_target_q;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (1'b1),
    .wr_lo_i (csr_wr && (address_i == CSR_MCYCLE)),
    .wr_hi_i (csr_wr && (address_i == CSR_MCYCLEH)),
    .wdata_i (csr_new),
    .value_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (instret_i),
    .wr_lo_i (csr_wr && (address_i == CSR_MINSTRET)),
    .wr_hi_i (csr_wr && (address_i == CSR_MINSTRETH)),
    .wdata_i (csr_new),
    .value_o (minstret)
  );

endmodule

// File: tb/tb_machine_csr_file.sv
// Directed bench for machine_csr_file: CSR ops, traps, MRET, priority, counters and reset.
module tb_machine_csr_file;
  import machine_csr_file_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           read_enable_i = 1'b0, write_enable_i = 1'b0;
  csrOperation_e  operation_i = CSR_OP_NONE;
  logic [11:0]    address_i = '0;
  logic [31:0]    data_i = '0, pc_i = '0, tval_i = '0;
  logic           valid_i = 1'b0, exception_i = 1'b0, mret_i = 1'b0, instret_i = 1'b0;
  exceptionCode_e exception_code_i = EXC_INSTR_MISALIGNED;
  logic           meip_i = 1'b0, msip_i = 1'b0, mtip_i = 1'b0;
  logic [31:0]    out_o, jump_target_o;
  logic           illegal_o, irq_pending_o, jump_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] c1, c2;

  always #5 clk = ~clk;

  machine_csr_file #(.MHARTID_VAL(32'h0), .MTVEC_RESET(32'h0)) dut (
    .clk(clk), .reset(reset),
    .read_enable_i(read_enable_i), .write_enable_i(write_enable_i),
    .operation_i(operation_i), .address_i(address_i), .data_i(data_i),
    .out_o(out_o), .illegal_o(illegal_o),
    .valid_i(valid_i), .pc_i(pc_i), .exception_i(exception_i),
    .exception_code_i(exception_code_i), .tval_i(tval_i),
    .mret_i(mret_i), .instret_i(instret_i),
    .meip_i(meip_i), .msip_i(msip_i), .mtip_i(mtip_i),
    .irq_pending_o(irq_pending_o), .jump_o(jump_o), .jump_target_o(jump_target_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input csrOperation_e op, input logic [11:0] a, input logic [31:0] d);
    write_enable_i = 1'b1; operation_i = op; address_i = a; data_i = d;
    tick();
    write_enable_i = 1'b0; operation_i = CSR_OP_NONE;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] v);
    read_enable_i = 1'b1; address_i = a;
    #1;
    v = out_o;
    read_enable_i = 1'b0;
  endtask

  task automatic check_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csr_read(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    #2;
    check("jump_in_reset", 32'(jump_o), 32'd0);
    #10;
    reset = 1'b0;

    // Reset state and constants
    check_csr("mstatus_reset", CSR_MSTATUS, 32'h0000_1800);
    check_csr("misa", CSR_MISA, 32'h4000_0100);
    address_i = CSR_MISA; #1;
    check("out_zero_no_read", out_o, 32'd0);
    tick();
    csr_read(CSR_MCYCLE, c1);
    tick();
    csr_read(CSR_MCYCLE, c2);
    check("mcycle_small", 32'(c1 < 32'd16), 32'd1);
    check("mcycle_step", c2, c1 + 32'd1);

    // Set/clear on MIE, illegal write to read-only CSR
    csr_write(CSR_OP_SET, CSR_MIE, 32'h888);
    csr_write(CSR_OP_CLEAR, CSR_MIE, 32'h008);
    check_csr("mie_set_clear", CSR_MIE, 32'h880);
    write_enable_i = 1'b1; operation_i = CSR_OP_WRITE; address_i = CSR_MVENDORID; data_i = 32'h1234;
    #1;
    check("illegal_mvendorid", 32'(illegal_o), 32'd1);
    tick();
    write_enable_i = 1'b0; operation_i = CSR_OP_NONE;
    check_csr("mvendorid_kept", CSR_MVENDORID, 32'd0);
    check_csr("illegal_addr_reads0", 12'h7C0, 32'd0);

    // Exception trap
    csr_write(CSR_OP_WRITE, CSR_MTVEC, 32'h400);
    exception_i = 1'b1; exception_code_i = EXC_ILLEGAL_INSTR; pc_i = 32'h100; tval_i = 32'hDEAD;
    tick();
    exception_i = 1'b0;
    check("exc_jump", 32'(jump_o), 32'd1);
    check("exc_target", jump_target_o, 32'h400);
    check_csr("exc_mepc", CSR_MEPC, 32'h100);
    check_csr("exc_mcause", CSR_MCAUSE, 32'd2);
    check_csr("exc_mtval", CSR_MTVAL, 32'hDEAD);
    check_csr("exc_mstatus", CSR_MSTATUS, 32'h1800);
    tick();
    check("exc_jump_pulse", 32'(jump_o), 32'd0);

    // WARL fields
    csr_write(CSR_OP_WRITE, CSR_MTVEC, 32'h403);
    check_csr("mtvec_mode3", CSR_MTVEC, 32'h401);
    csr_write(CSR_OP_WRITE, CSR_MEPC, 32'h123);
    check_csr("mepc_align", CSR_MEPC, 32'h120);

    // Vectored timer interrupt
    csr_write(CSR_OP_WRITE, CSR_MIE, 32'h80);
    csr_write(CSR_OP_SET, CSR_MSTATUS, 32'h8);
    check_csr("mstatus_mie_set", CSR_MSTATUS, 32'h1808);
    mtip_i = 1'b1;
    #1;
    check("irq_not_yet", 32'(irq_pending_o), 32'd0);
    tick();
    check("irq_pending", 32'(irq_pending_o), 32'd1);
    valid_i = 1'b1; pc_i = 32'h200;
    tick();
    valid_i = 1'b0;
    check("mti_jump", 32'(jump_o), 32'd1);
    check("mti_target", jump_target_o, 32'h41C);
    check_csr("mti_mcause", CSR_MCAUSE, 32'h8000_0007);
    check_csr("mti_mepc", CSR_MEPC, 32'h200);
    check_csr("mti_mtval", CSR_MTVAL, 32'd0);
    check_csr("mti_mstatus", CSR_MSTATUS, 32'h1880);
    check("irq_masked", 32'(irq_pending_o), 32'd0);

    // MRET
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    check("mret_jump", 32'(jump_o), 32'd1);
    check("mret_target", jump_target_o, 32'h200);
    check_csr("mret_mstatus", CSR_MSTATUS, 32'h1888);

    // External interrupt beats timer
    mtip_i = 1'b0;
    tick();
    tick();
    csr_write(CSR_OP_WRITE, CSR_MIE, 32'h888);
    meip_i = 1'b1; mtip_i = 1'b1;
    tick();
    valid_i = 1'b1; pc_i = 32'h240;
    tick();
    valid_i = 1'b0; meip_i = 1'b0; mtip_i = 1'b0;
    check("mei_target", jump_target_o, 32'h42C);
    check_csr("mei_mcause", CSR_MCAUSE, 32'h8000_000B);

    // Exception beats MRET
    mret_i = 1'b1; exception_i = 1'b1; exception_code_i = EXC_BREAKPOINT; pc_i = 32'h300; tval_i = 32'd0;
    tick();
    mret_i = 1'b0; exception_i = 1'b0;
    check("excmret_jump", 32'(jump_o), 32'd1);
    check("excmret_target", jump_target_o, 32'h400);
    check_csr("excmret_mcause", CSR_MCAUSE, 32'd3);
    check_csr("excmret_mepc", CSR_MEPC, 32'h300);
    check_csr("excmret_mstatus", CSR_MSTATUS, 32'h1800);

    // Counters
    csr_write(CSR_OP_WRITE, CSR_MCYCLEH, 32'd0);
    csr_write(CSR_OP_WRITE, CSR_MCYCLE, 32'hFFFF_FFFF);
    check_csr("mcycle_written", CSR_MCYCLE, 32'hFFFF_FFFF);
    check_csr("mcycleh_written", CSR_MCYCLEH, 32'd0);
    tick();
    check_csr("mcycleh_carry", CSR_MCYCLEH, 32'd1);
    check_csr("mcycle_wrap", CSR_TIME, 32'd0);
    write_enable_i = 1'b1; operation_i = CSR_OP_WRITE; address_i = CSR_CYCLE; data_i = 32'd5;
    #1;
    check("illegal_cycle_write", 32'(illegal_o), 32'd1);
    write_enable_i = 1'b0; operation_i = CSR_OP_NONE;
    check_csr("instret_zero", CSR_INSTRET, 32'd0);
    instret_i = 1'b1;
    tick(); tick(); tick();
    instret_i = 1'b0;
    check_csr("minstret_three", CSR_MINSTRET, 32'd3);

    // Reset while a redirect is pending
    csr_write(CSR_OP_WRITE, CSR_MSCRATCH, 32'h5A5A_5A5A);
    check_csr("mscratch", CSR_MSCRATCH, 32'h5A5A_5A5A);
    exception_i = 1'b1; exception_code_i = EXC_ILLEGAL_INSTR; pc_i = 32'h500;
    tick();
    exception_i = 1'b0;
    check("pre_reset_jump", 32'(jump_o), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_kills_jump", 32'(jump_o), 32'd0);
    check("reset_target", jump_target_o, 32'd0);
    check_csr("reset_mstatus", CSR_MSTATUS, 32'h1800);
    check_csr("reset_mscratch", CSR_MSCRATCH, 32'd0);
    check_csr("reset_mtvec", CSR_MTVEC, 32'd0);
    check_csr("reset_mcycleh", CSR_MCYCLEH, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
